// File: rtl/codec_cfg_sequencer.sv
// codec_cfg_sequencer
//   Power-up configuration sequencer for the WM8731 codec. Walks an 11-entry
//   register table and hands one 24-bit word {DEV_ADDR, reg[6:0], data[8:0]}
//   per entry to an I2C master, checking the ACK result of each transfer.
//   Failed or timed-out writes are retried up to MAX_RETRY times. The block
//   then parks in DONE or ERROR until start or reset.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high
//   start        1-cycle pulse: begin or restart the sequence from entry 0
//   i2c_go       1-cycle pulse: i2c_word valid, master starts a transfer
//   i2c_word     {DEV_ADDR, reg[6:0], data[8:0]}, stable from LOAD to next LOAD
//   i2c_end      1-cycle pulse from master: transfer finished
//   i2c_ack_ok   qualifies i2c_end: 1 = all three bytes ACKed
//   busy         sequence in progress
//   done         every entry written and ACKed
//   error        an entry failed MAX_RETRY+1 attempts
//   cfg_index    current / failed entry (saturates at 10)
//
// Optional feature: define CODEC_RUNTIME_WRITE_EN to add wr_req/wr_reg/
//   wr_data/wr_ack. While DONE, wr_req writes one extra reg/data pair with
//   the same retry rules; success pulses wr_ack and returns to DONE.
//
// State table
//   state   | meaning
//   IDLE    | after reset, waiting for start
//   LOAD    | latch i2c_word for the current entry, clear timeout
//   ISSUE   | i2c_go high for one cycle
//   WAIT    | waiting for i2c_end, timeout counter running
//   RETRY   | decide between another attempt and ERROR
//   GAP     | idle spacing between transactions
//   DONE    | all entries written (terminal)
//   ERROR   | an entry exhausted its retries (terminal)

module codec_cfg_sequencer #(
  parameter logic [7:0]  DEV_ADDR    = 8'h34,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned GAP_CYCLES  = 2000,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        i2c_go,
  output logic [23:0] i2c_word,
  input  logic        i2c_end,
  input  logic        i2c_ack_ok,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [3:0]  cfg_index
`ifdef CODEC_RUNTIME_WRITE_EN
  ,
  input  logic        wr_req,
  input  logic [6:0]  wr_reg,
  input  logic [8:0]  wr_data,
  output logic        wr_ack
`endif
);

  localparam int GW = (GAP_CYCLES  > 1) ? $clog2(GAP_CYCLES + 1)  : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [2:0]    RETRY_MAX = 3'(MAX_RETRY);
  localparam logic [3:0]    LAST_IDX  = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_RETRY, S_GAP, S_DONE, S_ERROR
  } state_t;

  state_t          state, state_nx;
  logic [3:0]      cfg_index_q;
  logic [2:0]      retry_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            seq_last;   // entry 10 has been ACKed; next GAP exit goes to DONE
  logic [23:0]     word_q;
  logic            tmo_hit;
  logic            retry_ok;
  logic [15:0]     load_pair;

  logic            rt_mode;    // a runtime write is in flight
  logic [6:0]      rt_reg;
  logic [8:0]      rt_data;

  // {reg[6:0], data[8:0]}; R15 (reset) first, R9 (activate) last
  function automatic logic [15:0] cfg_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    cfg_entry = {7'h0F, 9'h000};
      4'd1:    cfg_entry = {7'h00, 9'h017};
      4'd2:    cfg_entry = {7'h01, 9'h017};
      4'd3:    cfg_entry = {7'h02, 9'h079};
      4'd4:    cfg_entry = {7'h03, 9'h079};
      4'd5:    cfg_entry = {7'h04, 9'h012};
      4'd6:    cfg_entry = {7'h05, 9'h000};
      4'd7:    cfg_entry = {7'h06, 9'h000};
      4'd8:    cfg_entry = {7'h07, 9'h042};
      4'd9:    cfg_entry = {7'h08, 9'h000};
      4'd10:   cfg_entry = {7'h09, 9'h001};
      default: cfg_entry = 16'h0000;
    endcase
  endfunction

  assign tmo_hit   = (tmo_cnt == TMO_LAST);
  assign retry_ok  = (retry_cnt < RETRY_MAX);
  assign load_pair = rt_mode ? {rt_reg, rt_data} : cfg_entry(cfg_index_q);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = S_IDLE;
      S_LOAD:  state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT: begin
        if (i2c_end) begin
          if (!i2c_ack_ok)  state_nx = S_RETRY;
          else if (rt_mode) state_nx = S_DONE;
          else              state_nx = S_GAP;
        end else if (tmo_hit) begin
          state_nx = S_RETRY;
        end
      end
      S_RETRY: state_nx = retry_ok ? S_GAP : S_ERROR;
      S_GAP: begin
        if (gap_cnt == '0) state_nx = (seq_last && !rt_mode) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
`ifdef CODEC_RUNTIME_WRITE_EN
        if (wr_req) state_nx = S_LOAD;
`endif
      end
      S_ERROR: state_nx = S_ERROR;
    endcase
    // start aborts anything in progress, including a pending runtime write
    if (start) state_nx = S_LOAD;
  end

  always_comb begin
    i2c_go = (state == S_ISSUE);
    busy   = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);
    done   = (state == S_DONE) || rt_mode;
    error  = (state == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_index_q <= '0;
      retry_cnt   <= '0;
      gap_cnt     <= '0;
      tmo_cnt     <= '0;
      seq_last    <= 1'b0;
      word_q      <= '0;
    end else if (start) begin
      cfg_index_q <= '0;
      retry_cnt   <= '0;
      gap_cnt     <= '0;
      tmo_cnt     <= '0;
      seq_last    <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          word_q  <= {DEV_ADDR, load_pair};
          tmo_cnt <= '0;
        end
        S_WAIT: begin
          if (i2c_end) begin
            if (i2c_ack_ok) begin
              retry_cnt <= '0;
              gap_cnt   <= GAP_LAST;
              if (!rt_mode) begin
                if (cfg_index_q == LAST_IDX) seq_last    <= 1'b1;
                else                         cfg_index_q <= cfg_index_q + 4'd1;
              end
            end
          end else if (!tmo_hit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_RETRY: begin
          if (retry_ok) begin
            retry_cnt <= retry_cnt + 3'd1;
            gap_cnt   <= GAP_LAST;
          end
        end
        S_GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CODEC_RUNTIME_WRITE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rt_mode <= 1'b0;
      rt_reg  <= '0;
      rt_data <= '0;
      wr_ack  <= 1'b0;
    end else begin
      wr_ack <= 1'b0;
      if (start) begin
        rt_mode <= 1'b0;
      end else if (state == S_DONE && wr_req) begin
        rt_mode <= 1'b1;
        rt_reg  <= wr_reg;
        rt_data <= wr_data;
      end else if (state == S_WAIT && rt_mode && i2c_end && i2c_ack_ok) begin
        rt_mode <= 1'b0;
        wr_ack  <= 1'b1;
      end else if (state == S_RETRY && rt_mode && !retry_ok) begin
        rt_mode <= 1'b0;
      end
    end
  end
`else
  assign rt_mode = 1'b0;
  assign rt_reg  = '0;
  assign rt_data = '0;
`endif

  assign i2c_word  = word_q;
  assign cfg_index = cfg_index_q;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
module tb_codec_cfg_sequencer;

  localparam int GAP = 20;
  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        i2c_end = 1'b0;
  logic        i2c_ack_ok = 1'b0;
  logic        i2c_go;
  logic [23:0] i2c_word;
  logic        busy, done, error;
  logic [3:0]  cfg_index;
`ifdef CODEC_RUNTIME_WRITE_EN
  logic        wr_req = 1'b0;
  logic [6:0]  wr_reg = '0;
  logic [8:0]  wr_data = '0;
  logic        wr_ack;
`endif

  always #5 clk = ~clk;

  codec_cfg_sequencer #(
    .DEV_ADDR   (8'h34),
    .MAX_RETRY  (3),
    .GAP_CYCLES (GAP),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .i2c_go    (i2c_go),
    .i2c_word  (i2c_word),
    .i2c_end   (i2c_end),
    .i2c_ack_ok(i2c_ack_ok),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .cfg_index (cfg_index)
`ifdef CODEC_RUNTIME_WRITE_EN
    ,
    .wr_req    (wr_req),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack)
`endif
  );

  typedef struct {
    logic [23:0] word;
    logic [3:0]  idx;
    logic        ack;
    logic        send_end;
  } vec_t;

  vec_t        vec[$];
  logic [23:0] exp_word [0:10];
  int          n_checks = 0;
  int          n_errors = 0;
  int          go_cnt = 0;
  int          go_base;
  time         t_start;
  time         go_t[$];

  always @(posedge clk) if (i2c_go === 1'b1) go_cnt <= go_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add_vec(input int idx, input logic ack, input logic send);
    vec_t v;
    v.word = exp_word[idx];
    v.idx = 4'(idx);
    v.ack = ack;
    v.send_end = send;
    vec.push_back(v);
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    t_start = $time;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic respond(input logic ack);
    repeat (2) @(negedge clk);
    i2c_end = 1'b1;
    i2c_ack_ok = ack;
    @(negedge clk);
    i2c_end = 1'b0;
    i2c_ack_ok = 1'b0;
  endtask

  task automatic wait_go(input string name, output bit ok);
    int k;
    ok = 1'b0;
    k = 0;
    while (!ok && k < 500) begin
      @(negedge clk);
      k++;
      if (i2c_go === 1'b1) ok = 1'b1;
    end
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: i2c_go seen=0 expected 1 within 500 cycles", name);
    end
  endtask

  task automatic run_vectors(input string tag, input bit chk_latency);
    bit ok;
    for (int i = 0; i < vec.size(); i++) begin
      wait_go($sformatf("%s_go%0d", tag, i), ok);
      if (!ok) begin
        vec.delete();
        return;
      end
      go_t.push_back($time);
      if (chk_latency && i == 0)
        check("start_to_go_cycles", 32'(($time - t_start) / 10), 32'd2);
      check($sformatf("%s_word%0d", tag, i), 32'(i2c_word), 32'(vec[i].word));
      check($sformatf("%s_idx%0d", tag, i), 32'(cfg_index), 32'(vec[i].idx));
      @(negedge clk);
      check($sformatf("%s_go_width%0d", tag, i), 32'(i2c_go), 32'd0);
      if (vec[i].send_end) respond(vec[i].ack);
    end
    vec.delete();
  endtask

  task automatic wait_final(input string tag, input logic exp_done, input logic exp_err);
    int k;
    bit hit;
    k = 0;
    hit = 1'b0;
    while (!hit && k < 300) begin
      @(negedge clk);
      k++;
      if (done === 1'b1 || error === 1'b1) hit = 1'b1;
    end
    check({tag, "_terminal_reached"}, 32'(hit), 32'd1);
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_error"}, 32'(error), 32'(exp_err));
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time exceeded, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    exp_word[0]  = 24'h341E00;
    exp_word[1]  = 24'h340017;
    exp_word[2]  = 24'h340217;
    exp_word[3]  = 24'h340479;
    exp_word[4]  = 24'h340679;
    exp_word[5]  = 24'h340812;
    exp_word[6]  = 24'h340A00;
    exp_word[7]  = 24'h340C00;
    exp_word[8]  = 24'h340E42;
    exp_word[9]  = 24'h341000;
    exp_word[10] = 24'h341201;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_go", 32'(i2c_go), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_index", 32'(cfg_index), 32'd0);
    check("rst_word", 32'(i2c_word), 32'd0);
    reset = 1'b0;
    // stray i2c_end in IDLE
    @(negedge clk);
    i2c_end = 1'b1;
    i2c_ack_ok = 1'b1;
    @(negedge clk);
    i2c_end = 1'b0;
    i2c_ack_ok = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_go_cnt", 32'(go_cnt), 32'd0);

    // nominal sequence
    go_base = go_cnt;
    for (int i = 0; i <= 10; i++) add_vec(i, 1'b1, 1'b1);
    pulse_start();
    check("load_go_low", 32'(i2c_go), 32'd0);
    check("load_busy", 32'(busy), 32'd1);
    run_vectors("nom", 1'b1);
    wait_final("nom", 1'b1, 1'b0);
    check("nom_go_total", 32'(go_cnt - go_base), 32'd11);
    check("nom_index_sat", 32'(cfg_index), 32'd10);

`ifdef CODEC_RUNTIME_WRITE_EN
    // runtime write from DONE
    @(negedge clk);
    wr_req = 1'b1;
    wr_reg = 7'h02;
    wr_data = 9'h060;
    @(negedge clk);
    wr_req = 1'b0;
    wait_go("rt_go", ok);
    check("rt_word", 32'(i2c_word), 32'h00340460);
    repeat (3) @(negedge clk);
    i2c_end = 1'b1;
    i2c_ack_ok = 1'b1;
    @(negedge clk);
    i2c_end = 1'b0;
    i2c_ack_ok = 1'b0;
    check("rt_wr_ack", 32'(wr_ack), 32'd1);
    check("rt_done", 32'(done), 32'd1);
    @(negedge clk);
    check("rt_wr_ack_width", 32'(wr_ack), 32'd0);
    check("rt_done_hold", 32'(done), 32'd1);
    check("rt_busy", 32'(busy), 32'd0);
`endif

    // NACK recovery on entry 3
    go_base = go_cnt;
    for (int i = 0; i <= 2; i++) add_vec(i, 1'b1, 1'b1);
    add_vec(3, 1'b0, 1'b1);
    add_vec(3, 1'b0, 1'b1);
    for (int i = 3; i <= 10; i++) add_vec(i, 1'b1, 1'b1);
    pulse_start();
    run_vectors("nack", 1'b0);
    wait_final("nack", 1'b1, 1'b0);
    check("nack_go_total", 32'(go_cnt - go_base), 32'd13);

    // hard failure on entry 5
    go_base = go_cnt;
    for (int i = 0; i <= 4; i++) add_vec(i, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) add_vec(5, 1'b0, 1'b1);
    pulse_start();
    run_vectors("hard", 1'b0);
    wait_final("hard", 1'b0, 1'b1);
    check("hard_index", 32'(cfg_index), 32'd5);
    repeat (150) @(negedge clk);
    check("hard_go_total", 32'(go_cnt - go_base), 32'd9);
    check("hard_error_hold", 32'(error), 32'd1);

    // timeout on entry 0: WAIT 50 + RETRY 1 + GAP 20 + LOAD 1 + ISSUE 1
    go_base = go_cnt;
    go_t.delete();
    for (int i = 0; i < 4; i++) add_vec(0, 1'b0, 1'b0);
    pulse_start();
    run_vectors("tmo", 1'b0);
    if (go_t.size() >= 2)
      check("tmo_retry_spacing", 32'((go_t[1] - go_t[0]) / 10), 32'd73);
    wait_final("tmo", 1'b0, 1'b1);
    check("tmo_index", 32'(cfg_index), 32'd0);
    repeat (100) @(negedge clk);
    check("tmo_go_total", 32'(go_cnt - go_base), 32'd4);

    // restart during WAIT of entry 6, stray i2c_end in LOAD and GAP
    for (int i = 0; i <= 5; i++) add_vec(i, 1'b1, 1'b1);
    add_vec(6, 1'b1, 1'b0);
    pulse_start();
    run_vectors("pre", 1'b0);
    repeat (3) @(negedge clk);
    go_base = go_cnt;
    start = 1'b1;
    t_start = $time;
    @(negedge clk);
    start = 1'b0;
    i2c_end = 1'b1;
    i2c_ack_ok = 1'b1;
    check("rs_load_go_low", 32'(i2c_go), 32'd0);
    @(negedge clk);
    i2c_end = 1'b0;
    i2c_ack_ok = 1'b0;
    check("rs_go", 32'(i2c_go), 32'd1);
    check("rs_latency", 32'(($time - t_start) / 10), 32'd2);
    check("rs_word", 32'(i2c_word), 32'h00341E00);
    check("rs_index", 32'(cfg_index), 32'd0);
    @(negedge clk);
    respond(1'b1);
    repeat (3) @(negedge clk);
    i2c_end = 1'b1;
    i2c_ack_ok = 1'b1;
    @(negedge clk);
    i2c_end = 1'b0;
    i2c_ack_ok = 1'b0;
    for (int i = 1; i <= 10; i++) add_vec(i, 1'b1, 1'b1);
    run_vectors("rs", 1'b0);
    wait_final("rs", 1'b1, 1'b0);
    check("rs_go_total", 32'(go_cnt - go_base), 32'd11);

    // reset mid-transfer
    pulse_start();
    wait_go("mid_go", ok);
    repeat (2) @(negedge clk);
    go_base = go_cnt;
    reset = 1'b1;
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_error", 32'(error), 32'd0);
    check("mid_index", 32'(cfg_index), 32'd0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("mid_no_go", 32'(go_cnt - go_base), 32'd0);
    check("mid_idle_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
